// File: rtl/step_ctrl_pkg.sv
// Shared definitions for step_controller: button FSM encoding, default timing
// constants and the counter-width helper.
package step_ctrl_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 1000000;   // 20 ms at 50 MHz
    localparam int RUN_DIV_DEF         = 25000000;  // 2 Hz at 50 MHz
    localparam int STEP_COUNT_W        = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        FIRE       = 3'd2,
        HELD       = 3'd3,
        DB_RELEASE = 3'd4
    } btn_state_t;

    // Bits needed for a counter that runs 0..n-1 (never narrower than 1).
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_controller_if.sv
// Signal bundle between the board controls and step_controller.
// master drives the raw controls; slave (the controller) drives the step outputs.
interface step_controller_if;
    import step_ctrl_pkg::*;

    logic                    stepBtn;
    logic                    runSw;
    logic                    halt;
    logic                    stepEn;
    logic [STEP_COUNT_W-1:0] stepCount;
    logic                    running;

    modport master (
        output stepBtn, runSw, halt,
        input  stepEn, stepCount, running
    );

    modport slave (
        input  stepBtn, runSw, halt,
        output stepEn, stepCount, running
    );

endinterface

// File: rtl/step_controller_btn_sync.sv
// Two-flop synchronizer for an asynchronous board input into the clk50M domain.
// Both stages clear on reset so a level held through reset looks like a fresh edge.
module btn_sync (
    input  logic clk50M,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);
    logic meta;

    always_ff @(posedge clk50M) begin
        if (reset) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/step_controller.sv
// Step-enable generator: debounced single-step button plus optional run mode.
// Define STEP_CTRL_RUN_EN to compile in the runSw-driven free-running divider.
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | button released, waiting for a synced press
// DB_PRESS   | press seen, counting stable-high cycles
// FIRE       | press accepted, one-cycle step request
// HELD       | button still down after firing, waiting for release
// DB_RELEASE | release seen, counting stable-low cycles
module step_controller
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int RUN_DIV         = RUN_DIV_DEF
) (
    input  logic             clk50M,
    input  logic             reset,
    step_controller_if.slave bus
);

    localparam int             DBW     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || RUN_DIV < 2) begin : g_param_check
        $error("step_controller: need DEBOUNCE_CYCLES >= 1 and RUN_DIV >= 2");
    end

    logic                    btn_s;
    btn_state_t              state;
    btn_state_t              state_next;
    logic [DBW-1:0]          db_cnt;
    logic [DBW-1:0]          db_cnt_next;
    logic                    btn_fire;
    logic                    run_mode;
    logic                    run_tick;
    logic                    step_d;
    logic                    step_en_q;
    logic [STEP_COUNT_W-1:0] count_q;

    btn_sync u_btn_sync (
        .clk50M   (clk50M),
        .reset    (reset),
        .async_in (bus.stepBtn),
        .sync_out (btn_s)
    );

    always_ff @(posedge clk50M) begin
        if (reset) begin
            state  <= IDLE;
            db_cnt <= '0;
        end else begin
            state  <= state_next;
            db_cnt <= db_cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        db_cnt_next = db_cnt;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next  = DB_PRESS;
                    db_cnt_next = '0;
                end
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_next = FIRE;
                end else begin
                    db_cnt_next = db_cnt + DBW'(1);
                end
            end
            FIRE: begin
                state_next = HELD;
            end
            HELD: begin
                if (!btn_s) begin
                    state_next  = DB_RELEASE;
                    db_cnt_next = '0;
                end
            end
            DB_RELEASE: begin
                if (btn_s) begin
                    state_next = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_next = IDLE;
                end else begin
                    db_cnt_next = db_cnt + DBW'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                db_cnt_next = '0;
            end
        endcase
    end

    // Registering on the edge that enters FIRE puts stepEn in the FIRE cycle itself.
    assign btn_fire = (state_next == FIRE);

`ifdef STEP_CTRL_RUN_EN
    localparam int             RDW      = cnt_width(RUN_DIV);
    localparam logic [RDW-1:0] RUN_LAST = RDW'(RUN_DIV - 1);

    logic           run_s;
    logic           run_s_q;
    logic           run_changed;
    logic [RDW-1:0] div_cnt;

    btn_sync u_run_sync (
        .clk50M   (clk50M),
        .reset    (reset),
        .async_in (bus.runSw),
        .sync_out (run_s)
    );

    assign run_changed = (run_s != run_s_q);

    always_ff @(posedge clk50M) begin
        if (reset) begin
            run_s_q <= 1'b0;
            div_cnt <= '0;
        end else begin
            run_s_q <= run_s;
            if (run_changed) begin
                div_cnt <= '0;
            end else if (run_s && !bus.halt) begin
                div_cnt <= (div_cnt == RUN_LAST) ? '0 : div_cnt + RDW'(1);
            end
        end
    end

    assign run_mode    = run_s;
    assign run_tick    = run_s && !run_changed && !bus.halt && (div_cnt == RUN_LAST);
    assign bus.running = run_s && !bus.halt && !reset;
`else
    assign run_mode    = 1'b0;
    assign run_tick    = 1'b0;
    assign bus.running = 1'b0;
`endif

    // The back-to-back guard only matters on the edge where run mode switches off.
    assign step_d = !bus.halt && !step_en_q && (run_mode ? run_tick : btn_fire);

    always_ff @(posedge clk50M) begin
        if (reset) begin
            step_en_q <= 1'b0;
            count_q   <= '0;
        end else begin
            step_en_q <= step_d;
            if (step_d) begin
                count_q <= count_q + STEP_COUNT_W'(1);
            end
        end
    end

    assign bus.stepEn    = step_en_q;
    assign bus.stepCount = count_q;

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller (DEBOUNCE_CYCLES=4, RUN_DIV=8):
// fixed vector table, hand-written corner sequences and a random run against a run-length model.
module tb_step_controller;

    localparam int DB = 4;
    localparam int RD = 8;

    logic clk50M = 1'b0;
    logic reset;
    always #10 clk50M = ~clk50M;

    step_controller_if bus ();

    step_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD)) dut (
        .clk50M (clk50M),
        .reset  (reset),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    bit in_rst  = 1'b1;
    bit in_btn  = 1'b0;
    bit in_run  = 1'b0;
    bit in_halt = 1'b0;

    // Reference model: raw levels two edges old feed a run-length debouncer.
    bit          h0, h1, r0, r1, run_prev;
    bit          armed, skip;
    int          run_len, phase;
    bit          m_step, m_running;
    logic [15:0] m_cnt;

    typedef struct {
        bit          rst;
        bit          btn;
        bit          halt;
        bit          run;
        bit          exp_en;
        logic [15:0] exp_cnt;
        bit          exp_running;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit btn, bit halt, bit en, logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.btn = btn; v.halt = halt; v.run = 1'b0;
        v.exp_en = en; v.exp_cnt = cnt; v.exp_running = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit fsm_in, run_now, fire, tick, want;
        if (in_rst) begin
            h0 = 0; h1 = 0; r0 = 0; r1 = 0; run_prev = 0;
            armed = 1; skip = 0; run_len = 0; phase = 0;
            m_step = 0; m_running = 0; m_cnt = 16'h0000;
            return;
        end
        fsm_in  = h1;
        run_now = r1;
        h1 = h0; h0 = in_btn;
        r1 = r0; r0 = in_run;
        fire = 0;
        if (skip) begin
            skip = 0;
        end else if (armed) begin
            if (fsm_in) begin
                run_len++;
                if (run_len == DB + 1) begin
                    fire = 1; armed = 0; run_len = 0; skip = 1;
                end
            end else begin
                run_len = 0;
            end
        end else begin
            if (!fsm_in) begin
                run_len++;
                if (run_len == DB + 1) begin
                    armed = 1; run_len = 0;
                end
            end else begin
                run_len = 0;
            end
        end
        tick = 0;
`ifdef STEP_CTRL_RUN_EN
        if (run_now != run_prev) begin
            phase = 0;
        end else if (run_now && !in_halt) begin
            phase++;
            if (phase == RD) begin
                tick = 1; phase = 0;
            end
        end
        run_prev  = run_now;
        want      = run_now ? tick : fire;
        m_running = r1 && !in_halt;
`else
        want      = fire;
        m_running = 0;
`endif
        m_step = want && !in_halt && !m_step;
        if (m_step) m_cnt = m_cnt + 16'h0001;
    endtask

    task automatic cycle();
        @(negedge clk50M);
        reset       = in_rst;
        bus.stepBtn = in_btn;
        bus.runSw   = in_run;
        bus.halt    = in_halt;
        @(posedge clk50M);
        model_edge();
        #1;
        check("model_stepEn", 32'(bus.stepEn), 32'(m_step));
        check("model_stepCount", 32'(bus.stepCount), 32'(m_cnt));
        check("model_running", 32'(bus.running), 32'(m_running));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse, first, last, hold;
        bit saw_running;

        // Clean press held 20 cycles, then halt-suppressed press, then normal press.
        vecs.push_back(mk(1, 0, 0, 0, 16'd0));
        for (int i = 0; i < 20; i++) vecs.push_back(mk(0, 1, 0, i == 6, (i >= 6) ? 16'd1 : 16'd0));
        for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 0, 0, 16'd1));
        vecs.push_back(mk(1, 0, 0, 0, 16'd0));
        for (int i = 0; i < 20; i++) vecs.push_back(mk(0, 1, 1, 0, 16'd0));
        for (int i = 0; i < 12; i++) vecs.push_back(mk(0, 0, 0, 0, 16'd0));
        for (int i = 0; i < 20; i++) vecs.push_back(mk(0, 1, 0, i == 6, (i >= 6) ? 16'd1 : 16'd0));

        reset = 1'b1; bus.stepBtn = 1'b0; bus.runSw = 1'b0; bus.halt = 1'b0;

        foreach (vecs[i]) begin
            in_rst = vecs[i].rst; in_btn = vecs[i].btn;
            in_halt = vecs[i].halt; in_run = vecs[i].run;
            cycle();
            check($sformatf("tbl%0d_stepEn", i), 32'(bus.stepEn), 32'(vecs[i].exp_en));
            check($sformatf("tbl%0d_stepCount", i), 32'(bus.stepCount), 32'(vecs[i].exp_cnt));
            check($sformatf("tbl%0d_running", i), 32'(bus.running), 32'(vecs[i].exp_running));
        end

        // Bounce 1,0,1,1,0 then steady high: single pulse once 5 synced highs line up.
        in_rst = 1; in_btn = 0; in_halt = 0; cycle();
        in_rst = 0;
        npulse = 0; first = -1;
        for (int k = 0; k < 20; k++) begin
            in_btn = (k == 1 || k == 4) ? 1'b0 : 1'b1;
            cycle();
            if (bus.stepEn) begin
                npulse++;
                if (first < 0) first = k;
            end
        end
        check("bounce_pulses", 32'(npulse), 32'd1);
        check("bounce_edge", 32'(first), 32'd11);
        check("bounce_count", 32'(bus.stepCount), 32'd1);

        // Reset while in DB_PRESS with the button held: re-debounce from scratch.
        in_rst = 1; in_btn = 0; cycle();
        in_rst = 0; in_btn = 1;
        for (int k = 0; k < 4; k++) cycle();
        in_rst = 1; cycle(); cycle();
        in_rst = 0;
        npulse = 0; first = -1;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (bus.stepEn) begin
                npulse++;
                if (first < 0) first = k;
            end
        end
        check("rstpress_pulses", 32'(npulse), 32'd1);
        check("rstpress_edge", 32'(first), 32'd6);
        check("rstpress_count", 32'(bus.stepCount), 32'd1);

        // Count wrap: preload 16'hFFFF, one press must land on zero.
        in_btn = 0;
        for (int k = 0; k < 10; k++) cycle();
        @(negedge clk50M);
        force dut.count_q = 16'hFFFF;
        @(posedge clk50M);
        model_edge();
        #1;
        release dut.count_q;
        m_cnt = 16'hFFFF;
        check("preload_count", 32'(bus.stepCount), 32'h0000FFFF);
        in_btn = 1;
        npulse = 0;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (bus.stepEn) npulse++;
        end
        check("wrap_pulses", 32'(npulse), 32'd1);
        check("wrap_count", 32'(bus.stepCount), 32'd0);

        // Run switch.
        in_rst = 1; in_btn = 0; cycle();
        in_rst = 0; in_run = 1;
        npulse = 0; first = -1; last = -1; saw_running = 0;
`ifdef STEP_CTRL_RUN_EN
        for (int k = 0; k < 44; k++) begin
            cycle();
            if (bus.stepEn) begin
                npulse++;
                if (first < 0) first = k;
                else check("run_spacing", 32'(k - last), 32'(RD));
                last = k;
            end
        end
        check("run_pulses", 32'(npulse), 32'd5);
        check("run_first", 32'(first), 32'd10);
        check("run_running", 32'(bus.running), 32'd1);
        in_halt = 1;
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (bus.stepEn) npulse++;
            if (bus.running) saw_running = 1;
        end
        check("halt_pulses", 32'(npulse), 32'd0);
        check("halt_running", 32'(saw_running), 32'd0);
`else
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (bus.stepEn) npulse++;
            if (bus.running) saw_running = 1;
        end
        check("norun_pulses", 32'(npulse), 32'd0);
        check("norun_running", 32'(saw_running), 32'd0);
`endif
        in_halt = 0; in_run = 0;

        // Random traffic against the model.
        in_rst = 1; cycle();
        in_rst = 0;
        hold = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hold == 0) begin
                in_btn = !in_btn;
                hold = $urandom_range(1, 14);
            end
            hold--;
            if (in_halt) begin
                if ($urandom_range(0, 3) == 0) in_halt = 0;
            end else if ($urandom_range(0, 29) == 0) begin
                in_halt = 1;
            end
            if ($urandom_range(0, 199) == 0) in_run = !in_run;
            in_rst = ($urandom_range(0, 499) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, which sets the number of stable cycles a button level must hold (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter RUN_DIV, default 25000000, which sets the cycles between automatic steps in run mode (2 Hz).
REQ-003 The block SHALL have port clk50M, input, 1 bit: the single board clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port stepBtn, input, 1 bit: raw, asynchronous, bouncing step push-button.
REQ-006 The block SHALL have port runSw, input, 1 bit: run-mode switch, asynchronous.
REQ-007 The block SHALL have port halt, input, 1 bit: pipeline halt request, synchronous to clk50M.
REQ-008 The block SHALL have port stepEn, output, 1 bit: one-cycle clock-enable pulse that advances the pipeline by one cycle.
REQ-009 The block SHALL have port stepCount, output, 16 bits: number of stepEn pulses issued, shown on the SSD.
REQ-010 The block SHALL have port running, output, 1 bit: high while run mode is active and halt is low.

Function
REQ-011 stepBtn and runSw SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 The button FSM SHALL have the states IDLE, DB_PRESS, FIRE, HELD and DB_RELEASE.
REQ-013 In IDLE, a synced button at 1 SHALL move the FSM to DB_PRESS with the debounce counter cleared to 0.
REQ-014 In DB_PRESS, a synced button at 0 SHALL return the FSM to IDLE; otherwise the counter SHALL increment, and when it equals DEBOUNCE_CYCLES-1 the FSM SHALL move to FIRE.
REQ-015 FIRE SHALL last exactly one cycle and then go to HELD.
REQ-016 HELD SHALL be held while the synced button is 1; a synced button at 0 SHALL move the FSM to DB_RELEASE with the counter cleared.
REQ-017 In DB_RELEASE, a synced button at 1 SHALL return the FSM to HELD; when the counter equals DEBOUNCE_CYCLES-1 the FSM SHALL move to IDLE.
REQ-018 stepEn SHALL be registered and be high only in the cycle following edge DEBOUNCE_CYCLES+2, where edge 0 is the first edge that samples stepBtn high.
REQ-019 Holding the button indefinitely SHALL produce exactly one pulse.
REQ-020 halt=1 SHALL force stepEn to 0 and freeze stepCount; the FSM SHALL continue, so a press made during halt is consumed, not queued.
REQ-021 stepCount SHALL increment by 1 on every stepEn pulse and wrap from 16'hFFFF to 16'h0000.
REQ-022 stepEn SHALL never be high on two consecutive cycles.

Reset
REQ-023 While reset=1, the FSM SHALL be IDLE, all counters and synchronizer flops SHALL be 0, and stepEn, stepCount and running SHALL be 0.
REQ-024 A reset asserted mid-debounce or mid-run SHALL discard the pending step, with no pulse in the cycle after reset deasserts.
REQ-025 A button still held after reset SHALL be treated as a new press.

Configuration
REQ-026 Macro STEP_CTRL_RUN_EN SHALL control whether run mode is compiled in.
REQ-027 With STEP_CTRL_RUN_EN defined and synced runSw=1, a divider SHALL count 0..RUN_DIV-1 and stepEn SHALL pulse when the divider wraps.
REQ-028 With STEP_CTRL_RUN_EN defined and synced runSw=1, the button FSM SHALL run but its FIRE SHALL be ignored.
REQ-029 With STEP_CTRL_RUN_EN defined, any change of synced runSw SHALL clear the divider.
REQ-030 With STEP_CTRL_RUN_EN defined, halt=1 SHALL hold the divider.
REQ-031 Without STEP_CTRL_RUN_EN, runSw SHALL be ignored, no divider SHALL exist, and running SHALL be constant 0.

Structure
REQ-032 Package step_ctrl_pkg SHALL hold the FSM state encoding and the default DEBOUNCE_CYCLES/RUN_DIV constants.
REQ-033 Sub-module btn_sync SHALL be the 2-flop synchronizer, instantiated once per asynchronous input.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=8)
REQ-034 Clean press, stepBtn held 20 cycles -> exactly one stepEn pulse, in the cycle after edge 6; stepCount=1.
REQ-035 Bounce pattern 1,0,1,1,0 then steady 1 -> no pulse until 4 stable synced cycles, then exactly one pulse.
REQ-036 Press with halt=1 throughout -> no pulse and stepCount=0; release, deassert halt, press again -> stepCount=1.
REQ-037 Preload by 65535 presses (or force) then press once -> stepCount=0x0000.
REQ-038 RUN_EN build, runSw=1 for 40 cycles after sync -> 5 pulses spaced 8 cycles apart and running=1; assert halt -> pulses stop and running=0.
REQ-039 Reset asserted during DB_PRESS with the button still held -> no pulse at release of reset; one pulse 4+ cycles later after re-debounce.
